fc_out_streamer: RTL
====================

Name: fc_out_streamer

Overview:
Reads the fully-connected layer's output buffer after the layer signals completion. Streams the NUM_ENTRIES signed results to the next stage over a valid/ready interface, with full backpressure support.
Tracks the running argmax so the final classifier index is available without a second pass. Sits between the FC output RAM read port and the downstream layer or classification logic.

Parameters:
DATA_WIDTH, 16, width of each signed result word
NUM_ENTRIES, 120, number of words read and streamed per run
ADDR_WIDTH, 7, width of rd_addr and index fields (2^ADDR_WIDTH >= NUM_ENTRIES)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  single-cycle pulse (driven from FC done) that begins a run
rd_en  out  1  read strobe to FC output RAM
rd_addr  out  ADDR_WIDTH  read address to FC output RAM
rd_data  in  DATA_WIDTH  signed RAM data, valid exactly 1 cycle after rd_en
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_data  out  DATA_WIDTH  signed output word
m_index  out  ADDR_WIDTH  index of m_data (0..NUM_ENTRIES-1)
m_last  out  1  high with the word at index NUM_ENTRIES-1
busy  out  1  high in STREAM and DRAIN
done  out  1  high while in DONE
max_index  out  ADDR_WIDTH  argmax index of the words transferred so far
max_value  out  DATA_WIDTH  signed maximum of the words transferred so far

Behaviour:
- Reset: every output is 0, all counters are 0, the FIFO is emptied, and the state goes to IDLE. Reset aborts a run in any state, and any in-flight read data is discarded.
- State machine:
  - IDLE: on start, go to STREAM.
  - STREAM: issue reads. When the read at address NUM_ENTRIES-1 is issued, go to DRAIN.
  - DRAIN: no new reads. When the last-word handshake completes, go to DONE.
  - DONE: on start, go to STREAM with all counters cleared. Otherwise hold.
- start is ignored in STREAM and DRAIN.
- Read issue:
  - rd_en=1 only in STREAM, and only when occupancy + inflight - pop < 2, where:
    - occupancy = entries held in the 2-entry output FIFO
    - inflight = rd_en of the previous cycle
    - pop = m_valid & m_ready this cycle
  - rd_addr increments after each issued read and starts at 0.
  - rd_addr holds at NUM_ENTRIES-1 after the final read, and is never driven past NUM_ENTRIES-1.
- Capture: rd_data is written into the FIFO on the cycle after rd_en. A push and a pop in the same cycle are both honoured.
- FIFO: 2 entries. Each entry holds {data, index, last}. It never overflows; the credit rule guarantees this.
- Output:
  - m_valid = FIFO not empty.
  - m_data, m_index and m_last come from the FIFO head and stay stable while m_valid=1 and m_ready=0.
  - A transfer is a cycle with m_valid & m_ready.
- Throughput: with m_ready held at 1, the first m_valid comes 2 cycles after start (start->STREAM, read, capture). After that there is one word per cycle. The last transfer happens NUM_ENTRIES+1 cycles after start, and DONE follows on the next cycle.
- Argmax, updated on each transfer:
  - Index 0 loads max_value and max_index unconditionally.
  - Later words replace them only if data > max_value (signed, strict). Ties therefore keep the lower index.
  - max_index and max_value are cleared to 0 on start.
  - Their final values are stable in DONE.
- Widths: no arithmetic is performed on the data path beyond the signed compare. m_index equals the read address captured alongside the data.

Test Plan:
1. RAM[i]=i-60, m_ready=1, pulse start -> 120 transfers with m_data=-60..59 in order and m_last only at index 119. done is asserted 122 cycles after start; max_index=119, max_value=59.
2. Same data, m_ready toggling 1,0,0,1,... pseudo-randomly -> the identical ordered sequence with no drops or duplicates, m_data stable while stalled, and rd_en never creating a 3rd occupied slot.
3. RAM all -5 except RAM[37]=RAM[80]=300 -> max_index=37, max_value=300 (tie keeps the lower index).
4. RAM all 16'h8000 (most negative) -> max_index=0, max_value=-32768 (first-word load).
5. rst asserted after 50 transfers, then start again -> all outputs 0 in the cycle after rst. The second run restarts at index 0 and completes normally; a start pulse mid-run is ignored.
6. In DONE, pulse start with new RAM contents -> done drops, busy rises, and the new run's argmax is computed fresh from cleared values.

Source files
------------

// File: rtl/fc_out_streamer.sv
// Streams the FC output buffer to the next stage over valid/ready with a 2-entry
// skid FIFO, and tracks the running argmax of the words handed off.
//
// state  | meaning
// IDLE   | waiting for the first start after reset
// STREAM | issuing RAM reads under the FIFO credit rule
// DRAIN  | all reads issued, emptying the FIFO
// DONE   | last word transferred, argmax final; start re-arms
module fc_out_streamer #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_ENTRIES = 120,
    parameter int ADDR_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_index,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] max_index,
    output logic [DATA_WIDTH-1:0] max_value
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ENTRIES - 1);

    state_t state;
    state_t state_next;

    logic                  start_run;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_addr;

    logic [DATA_WIDTH-1:0] fifo_data  [2];
    logic [ADDR_WIDTH-1:0] fifo_index [2];
    logic                  fifo_last  [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic                  push;
    logic                  pop;
    logic [2:0]            credit;

    assign push    = inflight;
    assign m_valid = (count != 2'd0);
    assign pop     = m_valid & m_ready;
    assign m_data  = fifo_data[rd_ptr];
    assign m_index = fifo_index[rd_ptr];
    assign m_last  = fifo_last[rd_ptr];
    assign busy    = (state == STREAM) || (state == DRAIN);
    assign done    = (state == DONE);

    // Slots committed once this cycle's pop and the in-flight read land.
    assign credit = 3'(count) + 3'(inflight) - 3'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        start_run  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_run  = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (credit < 3'd2) begin
                    rd_en = 1'b1;
                    if (rd_addr == LAST_ADDR) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    start_run  = 1'b1;
                    state_next = STREAM;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr       <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                inflight_addr <= rd_addr;
            end
            if (start_run) begin
                rd_addr <= '0;
            end else if (rd_en && (rd_addr != LAST_ADDR)) begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i]  <= '0;
                fifo_index[i] <= '0;
                fifo_last[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr]  <= rd_data;
                fifo_index[wr_ptr] <= inflight_addr;
                fifo_last[wr_ptr]  <= (inflight_addr == LAST_ADDR);
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Index 0 loads unconditionally; strict compare keeps the lower index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_index <= '0;
            max_value <= '0;
        end else if (start_run) begin
            max_index <= '0;
            max_value <= '0;
        end else if (pop) begin
            if ((m_index == '0) || ($signed(m_data) > $signed(max_value))) begin
                max_index <= m_index;
                max_value <= m_data;
            end
        end
    end

endmodule
